// File: rtl/pim_conv_slicer.sv
// pim_conv_slicer: bit-sliced 3x3 PIM convolution sequencer.
// Issues every activation-slice x weight-slice op per filter and shift-accumulates the ADC results.
module pim_conv_slicer #(
   parameter  int DATA_W    = 6,
   parameter  int SLICE_W   = 3,
   parameter  int W_SLICES  = 2,
   parameter  int N_FILT    = 4,
   parameter  int ADC_P     = 6,
   parameter  int PIM_LAT   = 1,
   localparam int IN_SLICES = DATA_W / SLICE_W,
   localparam int K         = IN_SLICES * W_SLICES,
   localparam int MAX_SH    = SLICE_W * (IN_SLICES + W_SLICES - 2),
   localparam int ACC_W     = ADC_P + MAX_SH + $clog2(K),
   localparam int ADDR_W    = (N_FILT * W_SLICES > 1) ? $clog2(N_FILT * W_SLICES) : 1,
   localparam int FILT_W    = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [9*DATA_W-1:0]    in_data,
   output logic [9*SLICE_W-1:0]   pim_feature,
   output logic [ADDR_W-1:0]      pim_addr,
   output logic                   pim_en,
   input  logic [ADC_P-1:0]       pim_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_data,
   output logic [FILT_W-1:0]      out_filter,
   output logic                   out_last
);

   localparam int S_W  = (IN_SLICES > 1) ? $clog2(IN_SLICES) : 1;
   localparam int W_W  = (W_SLICES > 1) ? $clog2(W_SLICES) : 1;
   localparam int SH_W = (MAX_SH > 0) ? $clog2(MAX_SH + 1) : 1;

   // state   | meaning
   // S_IDLE  | waiting for a window, in_ready high
   // S_ISSUE | one PIM op per cycle, s fastest then w
   // S_DRAIN | waiting for in-flight results to land in acc
   // S_OUT   | presenting the filter result until accepted
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

   state_t               state_q, state_d;
   logic [9*DATA_W-1:0]  taps_q, taps_d;
   logic [FILT_W-1:0]    f_q, f_d;
   logic [S_W-1:0]       s_q, s_d;
   logic [W_W-1:0]       w_q, w_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [PIM_LAT-1:0]   tok_v_q, tok_v_d;
   logic [SH_W-1:0]      tok_sh_q [PIM_LAT];
   logic [SH_W-1:0]      tok_sh_d [PIM_LAT];
   logic [SH_W-1:0]      cur_sh;
   logic                 drain_busy;

   assign cur_sh = SH_W'(SLICE_W * (int'(s_q) + int'(w_q)));

   // The oldest token lands this cycle, so OUT may follow once nothing younger is in flight.
   always_comb begin
      drain_busy = 1'b0;
      for (int j = 0; j < PIM_LAT - 1; j++) drain_busy = drain_busy | tok_v_q[j];
   end

   always_comb begin
      state_d = state_q;
      taps_d  = taps_q;
      f_d     = f_q;
      s_d     = s_q;
      w_d     = w_q;
      acc_d   = acc_q;
      tok_v_d = '0;
      for (int j = 0; j < PIM_LAT; j++) tok_sh_d[j] = '0;
      for (int j = 1; j < PIM_LAT; j++) begin
         tok_v_d[j]  = tok_v_q[j-1];
         tok_sh_d[j] = tok_sh_q[j-1];
      end
      if (tok_v_q[PIM_LAT-1])
         acc_d = acc_q + (ACC_W'(pim_result) << tok_sh_q[PIM_LAT-1]);

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               taps_d  = in_data;
               f_d     = '0;
               s_d     = '0;
               w_d     = '0;
               acc_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tok_v_d[0]  = 1'b1;
            tok_sh_d[0] = cur_sh;
            if (s_q == S_W'(IN_SLICES - 1)) begin
               s_d = '0;
               if (w_q == W_W'(W_SLICES - 1)) begin
                  w_d     = '0;
                  state_d = S_DRAIN;
               end else begin
                  w_d = w_q + W_W'(1);
               end
            end else begin
               s_d = s_q + S_W'(1);
            end
         end
         S_DRAIN: begin
            if (!drain_busy) state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               if (f_q == FILT_W'(N_FILT - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  f_d     = f_q + FILT_W'(1);
                  acc_d   = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (clear) begin
         state_d = S_IDLE;
         tok_v_d = '0;
         for (int j = 0; j < PIM_LAT; j++) tok_sh_d[j] = '0;
         acc_d   = '0;
         f_d     = '0;
         s_d     = '0;
         w_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         taps_q   <= '0;
         f_q      <= '0;
         s_q      <= '0;
         w_q      <= '0;
         acc_q    <= '0;
         tok_v_q  <= '0;
         tok_sh_q <= '{default: '0};
      end else begin
         state_q  <= state_d;
         taps_q   <= taps_d;
         f_q      <= f_d;
         s_q      <= s_d;
         w_q      <= w_d;
         acc_q    <= acc_d;
         tok_v_q  <= tok_v_d;
         tok_sh_q <= tok_sh_d;
      end
   end

   always_comb begin
      pim_en      = 1'b0;
      pim_addr    = '0;
      pim_feature = '0;
      if (state_q == S_ISSUE) begin
         pim_en   = 1'b1;
         pim_addr = ADDR_W'(f_q) * ADDR_W'(W_SLICES) + ADDR_W'(w_q);
         for (int i = 0; i < 9; i++)
            pim_feature[(8-i)*SLICE_W +: SLICE_W] = taps_q[i*DATA_W + int'(s_q)*SLICE_W +: SLICE_W];
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_OUT);
   assign out_data   = out_valid ? acc_q : '0;
   assign out_filter = out_valid ? f_q : '0;
   assign out_last   = out_valid && (f_q == FILT_W'(N_FILT - 1));

endmodule

// File: tb/tb_pim_conv_slicer.sv
// Directed bench for pim_conv_slicer: default instance with PIM_LAT=1 and a second with PIM_LAT=3.
module tb_pim_conv_slicer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, clear, in_valid, out_ready;
   logic [53:0] in_data;
   logic        in_ready, pim_en, out_valid, out_last;
   logic [26:0] pim_feature;
   logic [2:0]  pim_addr;
   logic [5:0]  pim_result;
   logic [13:0] out_data;
   logic [1:0]  out_filter;

   logic        clear3, in_valid3, out_ready3;
   logic [53:0] in_data3;
   logic        in_ready3, pim_en3, out_valid3, out_last3;
   logic [26:0] pim_feature3;
   logic [2:0]  pim_addr3;
   logic [5:0]  pim_result3;
   logic [13:0] out_data3;
   logic [1:0]  out_filter3;

   int n_cmp = 0;
   int n_err = 0;
   int mode  = 0;

   pim_conv_slicer dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .pim_feature(pim_feature), .pim_addr(pim_addr), .pim_en(pim_en),
      .pim_result(pim_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_filter(out_filter), .out_last(out_last)
   );

   pim_conv_slicer #(.PIM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .clear(clear3), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_data(in_data3), .pim_feature(pim_feature3), .pim_addr(pim_addr3), .pim_en(pim_en3),
      .pim_result(pim_result3), .out_valid(out_valid3), .out_ready(out_ready3),
      .out_data(out_data3), .out_filter(out_filter3), .out_last(out_last3)
   );

   // Macro models: result only appears PIM_LAT cycles after a read strobe, zero otherwise.
   logic [5:0] res1 = '0;
   logic [5:0] p3 [3] = '{default: '0};
   always @(posedge clk) begin
      if (pim_en) res1 <= (mode == 1) ? (6'(pim_addr) + 6'd1) : 6'd7;
      else        res1 <= 6'd0;
      p3[0] <= pim_en3 ? 6'd63 : 6'd0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign pim_result  = res1;
   assign pim_result3 = p3[2];

   task automatic send_window(input bit use3, input logic [53:0] d);
      @(negedge clk);
      if (use3) begin in_valid3 = 1'b1; in_data3 = d; end
      else      begin in_valid  = 1'b1; in_data  = d; end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_valid3 = 1'b0;
   endtask

   task automatic wait_out(input bit use3, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (use3 ? out_valid3 : out_valid) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      clear3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (pim_en !== 1'b0) begin n_err++; $display("FAIL reset_pim_en got %b want 0", pim_en); end
      n_cmp++; if (pim_feature !== 27'd0) begin n_err++; $display("FAIL reset_pim_feature got %h want 0", pim_feature); end
      n_cmp++; if (pim_addr !== 3'd0) begin n_err++; $display("FAIL reset_pim_addr got %0d want 0", pim_addr); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 14'd0) begin n_err++; $display("FAIL reset_out_data got %0d want 0", out_data); end
      n_cmp++; if (out_filter !== 2'd0) begin n_err++; $display("FAIL reset_out_filter got %0d want 0", out_filter); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
      n_cmp++; if ({in_ready3, pim_en3, out_valid3, pim_feature3, pim_addr3} !== {1'b1, 1'b0, 1'b0, 27'd0, 3'd0}) begin
         n_err++; $display("FAIL reset_dut3 got rdy=%b en=%b ov=%b feat=%h addr=%0d want 1 0 0 0 0",
                           in_ready3, pim_en3, out_valid3, pim_feature3, pim_addr3);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_const();
      int c;
      mode = 0;
      send_window(1'b0, {9{6'h3F}});
      for (int f = 0; f < 4; f++) begin
         wait_out(1'b0, c);
         n_cmp++; if (c !== 6) begin n_err++; $display("FAIL const_latency f%0d got %0d want 6", f, c); end
         n_cmp++; if (out_data !== 14'd567) begin n_err++; $display("FAIL const_data f%0d got %0d want 567", f, out_data); end
         n_cmp++; if (out_filter !== 2'(f)) begin n_err++; $display("FAIL const_filter got %0d want %0d", out_filter, f); end
         n_cmp++; if (out_last !== (f == 3)) begin n_err++; $display("FAIL const_last f%0d got %b want %b", f, out_last, f == 3); end
      end
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL const_idle_ready got %b want 1", in_ready); end
   endtask

   task automatic test_addr_feature();
      int c;
      logic [53:0] d;
      logic [26:0] feat0, feat1, exp_feat;
      logic [2:0]  exp_addr;
      mode = 1;
      for (int i = 0; i < 9; i++) begin
         d[i*6 +: 6]         = 6'((8*i + 1) % 64);
         feat0[(8-i)*3 +: 3] = 3'd1;
         feat1[(8-i)*3 +: 3] = 3'(i % 8);
      end
      send_window(1'b0, d);
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_addr = 3'(2*f + k/2);
            exp_feat = (k % 2 == 0) ? feat0 : feat1;
            n_cmp++; if (pim_en !== 1'b1) begin n_err++; $display("FAIL addr_pim_en f%0d k%0d got %b want 1", f, k, pim_en); end
            n_cmp++; if (pim_addr !== exp_addr) begin n_err++; $display("FAIL addr_seq f%0d k%0d got %0d want %0d", f, k, pim_addr, exp_addr); end
            n_cmp++; if (pim_feature !== exp_feat) begin n_err++; $display("FAIL feature f%0d k%0d got %h want %h", f, k, pim_feature, exp_feat); end
         end
         wait_out(1'b0, c);
         n_cmp++; if (c !== 2) begin n_err++; $display("FAIL addr_drain f%0d got %0d want 2", f, c); end
         n_cmp++; if (out_data !== 14'((2*f + 1)*9 + (2*f + 2)*72)) begin
            n_err++; $display("FAIL addr_data f%0d got %0d want %0d", f, out_data, (2*f + 1)*9 + (2*f + 2)*72);
         end
      end
   endtask

   task automatic test_backpressure();
      int c;
      mode = 0;
      send_window(1'b0, {9{6'h3F}});
      wait_out(1'b0, c);
      n_cmp++; if (c !== 6 || out_filter !== 2'd0) begin n_err++; $display("FAIL bp_first got lat=%0d filt=%0d want 6 0", c, out_filter); end
      @(negedge clk);
      out_ready = 1'b0;
      wait_out(1'b0, c);
      n_cmp++; if (c !== 5 || out_filter !== 2'd1 || out_data !== 14'd567) begin
         n_err++; $display("FAIL bp_f1 got lat=%0d filt=%0d data=%0d want 5 1 567", c, out_filter, out_data);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({out_valid, out_data, out_filter, pim_en, in_ready} !== {1'b1, 14'd567, 2'd1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL bp_hold cyc%0d got ov=%b data=%0d filt=%0d en=%b rdy=%b want 1 567 1 0 0",
                              i, out_valid, out_data, out_filter, pim_en, in_ready);
         end
      end
      out_ready = 1'b1;
      for (int f = 2; f < 4; f++) begin
         wait_out(1'b0, c);
         n_cmp++; if (c !== 6 || out_filter !== 2'(f) || out_data !== 14'd567) begin
            n_err++; $display("FAIL bp_after f%0d got lat=%0d filt=%0d data=%0d want 6 %0d 567", f, c, out_filter, out_data, f);
         end
      end
   endtask

   task automatic test_lat3();
      int c;
      send_window(1'b1, {9{6'h3F}});
      for (int f = 0; f < 4; f++) begin
         wait_out(1'b1, c);
         n_cmp++; if (c !== 8) begin n_err++; $display("FAIL lat3_latency f%0d got %0d want 8", f, c); end
         n_cmp++; if (out_data3 !== 14'd5103) begin n_err++; $display("FAIL lat3_data f%0d got %0d want 5103", f, out_data3); end
         n_cmp++; if (out_filter3 !== 2'(f) || out_last3 !== (f == 3)) begin
            n_err++; $display("FAIL lat3_tag f%0d got filt=%0d last=%b want %0d %b", f, out_filter3, out_last3, f, f == 3);
         end
      end
   endtask

   task automatic test_clear();
      int c;
      bit seen;
      mode = 0;
      send_window(1'b0, {9{6'h3F}});
      for (int f = 0; f < 2; f++) begin
         wait_out(1'b0, c);
         n_cmp++; if (c !== 6 || out_filter !== 2'(f)) begin n_err++; $display("FAIL clr_pre f%0d got lat=%0d filt=%0d want 6 %0d", f, c, out_filter, f); end
      end
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_cmp++; if ({in_ready, out_valid, pim_en} !== 3'b100) begin
         n_err++; $display("FAIL clr_idle got rdy=%b ov=%b en=%b want 1 0 0", in_ready, out_valid, pim_en);
      end
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL clr_no_out got out_valid seen=%b want 0", seen); end

      send_window(1'b0, {9{6'h3F}});
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({in_ready, out_valid, pim_en} !== 3'b100) begin
         n_err++; $display("FAIL rst_mid got rdy=%b ov=%b en=%b want 1 0 0", in_ready, out_valid, pim_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_no_out got out_valid seen=%b want 0", seen); end

      send_window(1'b0, {9{6'h3F}});
      for (int f = 0; f < 4; f++) begin
         wait_out(1'b0, c);
         n_cmp++; if (c !== 6 || out_filter !== 2'(f) || out_data !== 14'd567) begin
            n_err++; $display("FAIL clr_recover f%0d got lat=%0d filt=%0d data=%0d want 6 %0d 567", f, c, out_filter, out_data, f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_const();
      test_addr_feature();
      test_backpressure();
      test_lat3();
      test_clear();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pim_conv_slicer.md
# pim_conv_slicer

Parametrised, sequenced successor of the 3x3 PIM convolution unit. Accepts one 3x3 window of unsigned activations and splits each activation into SLICE_W-bit slices. For every filter it issues all activation-slice × weight-slice reads to one shared PIM conv macro, shift-accumulates the ADC results at their correct binary weight, and streams one full-precision result per filter. It sits between the window buffer (upstream, valid/ready) and the output writer (downstream, valid/ready), and drives the PIM macro port directly.

## Interface
- DATA_W, 6: activation width; must be a multiple of SLICE_W
- SLICE_W, 3: bits per activation/weight slice
- W_SLICES, 2: weight slices stored per filter (consecutive PIM addresses)
- N_FILT, 4: filters per window
- ADC_P, 6: PIM result width, unsigned
- PIM_LAT, 1: cycles from pim_en to a valid pim_result (≥1)
- Derived: IN_SLICES=DATA_W/SLICE_W; K=IN_SLICES*W_SLICES; ACC_W=ADC_P+SLICE_W*(IN_SLICES+W_SLICES-2)+clog2(K); ADDR_W=clog2(N_FILT*W_SLICES)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; discards the current window
- in_valid  in  1  window valid
- in_ready  out  1  high only in IDLE
- in_data  in  9*DATA_W  taps 0..8, tap 0 at the LSBs
- pim_feature  out  9*SLICE_W  selected slice of each tap, tap 0 at the MSBs
- pim_addr  out  ADDR_W  f*W_SLICES+w
- pim_en  out  1  read strobe, one per issued op
- pim_result  in  ADC_P  macro output, valid PIM_LAT cycles after pim_en
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  ACC_W  accumulated filter result
- out_filter  out  clog2(N_FILT)  filter index of out_data
- out_last  out  1  high with the final filter of the window

## Operation
- States: IDLE → ISSUE → DRAIN → OUT → (ISSUE for the next filter | IDLE after the last filter).
- IDLE: in_ready=1. On in_valid, latch in_data, set f=0, clear the accumulator, go to ISSUE.
- ISSUE: one op per cycle, K cycles. Op index k=w*IN_SLICES+s, with s running fastest.
  - pim_feature = slice s (bits [SLICE_W*(s+1)-1 : SLICE_W*s]) of every tap.
  - pim_addr = f*W_SLICES+w; pim_en=1.
  - A PIM_LAT-deep token pipe carries the valid bit and shift amount SLICE_W*(s+w).
- Accumulate: when a token emerges, acc += zero-extended pim_result << shift. Unsigned arithmetic; ACC_W is sized so overflow cannot occur.
- DRAIN: wait until the token pipe is empty, then go to OUT.
- OUT: out_valid=1, with out_data=acc, out_filter=f, out_last=(f==N_FILT-1). Hold until out_ready.
  - On accept with f<N_FILT-1: f++, clear acc, go to ISSUE.
  - On accept with f==N_FILT-1: go to IDLE.
- clear in any state: next state IDLE; token pipe and acc zeroed; out_valid drops next cycle. Results still in flight in the macro are ignored.
- Outside ISSUE: pim_en=0 and pim_feature/pim_addr=0.

## Timing
- Reset values: state IDLE, in_ready=1, pim_en=0, pim_feature=0, pim_addr=0, out_valid=0, out_data=0, out_filter=0, out_last=0.
- Window accepted at edge T: pim_en is high for cycles T+1..T+K.
- Last result is sampled at the end of cycle T+K+PIM_LAT. out_valid rises in cycle T+K+PIM_LAT+1.
- Per-filter cost with out_ready held high: K+PIM_LAT+1 cycles. Subsequent filters start ISSUE the cycle after acceptance.
- out_* are stable while out_valid && !out_ready.
- in_ready is low from the cycle after acceptance until the cycle after the last out accept, or after clear.
- clear takes priority over in_valid and out_ready in the same cycle. That cycle's handshake does not complete.
- rst_n low mid-window: everything returns to reset values immediately. No partial output is ever emitted.

## Test plan
- Defaults (K=4, ACC_W=14, PIM_LAT=1, N_FILT=4). Model returns 7 for every op; all taps 6'h3F → four outputs of 567 (7·(1+8+8+64)), out_filter 0..3, out_last only on filter 3. First out_valid 6 cycles after accept.
- Address-weighted model, result = pim_addr+1 → filter f gives (2f+1)·9 + (2f+2)·72, e.g. f=0: 153, f=3: 639.
- Feature check: taps i=8i+1 → ops s=0 drive slices 1 on all taps; ops s=1 drive slice i. pim_addr sequence per filter is f·2, f·2, f·2+1, f·2+1.
- Backpressure: hold out_ready=0 for 10 cycles on filter 1 → out_data/out_filter stable, pim_en stays low, in_ready stays low; filter 2 proceeds after release.
- PIM_LAT=3, model max 63 → each output 5103, first out_valid 8 cycles after accept, no overflow.
- clear during ISSUE of filter 2, then rst_n pulse during DRAIN of a new window → no out_valid for the aborted window, in_ready=1 next cycle, and a following window produces correct results from filter 0.
